// File: rtl/vga_pixel_fetch_pkg.sv
// rtl/vga_pixel_fetch_pkg.sv - shared types and widths for the VGA pixel fetch path
package vga_pixel_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ACK     = 2'd2
  } swapState_t;

  localparam int ADDR_W  = 18;
  localparam int RED_W   = 3;
  localparam int GREEN_W = 3;
  localparam int BLUE_W  = 2;
  localparam int PIXEL_W = RED_W + GREEN_W + BLUE_W;

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - fixed-depth shift register keeping syncs aligned with fetched pixels
module sync_delay_line #(
  parameter int                WIDTH       = 1,
  parameter int                DEPTH       = 1,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '1
) (
  input  logic             clk25,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= RESET_VALUE;
    end else begin
      stages[0] <= dataIn;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign dataOut = stages[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// rtl/vga_pixel_fetch.sv - frame-buffer pixel fetch with double-buffer swap at vertical sync
module vga_pixel_fetch
  import vga_pixel_fetch_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic               clk25,
  input  logic               reset,
  input  logic               draw,
  input  logic [7:0]         xCoord,
  input  logic [8:0]         yCoord,
  input  logic               hSyncIn,
  input  logic               vSyncIn,
  output logic [ADDR_W-1:0]  memAddr,
  input  logic [PIXEL_W-1:0] memData,
  input  logic               swapReq,
  output logic               swapAck,
  output logic               backBank,
  output logic               frameStart,
  output logic [RED_W-1:0]   red,
  output logic [GREEN_W-1:0] green,
  output logic [BLUE_W-1:0]  blue,
  output logic               hSyncOut,
  output logic               vSyncOut
);

  // Address register + memory latency + output register.
  localparam int L = MEM_LATENCY + 2;

  swapState_t          state, nextState;
  logic                displayBank;
  logic                bankToggle;
  logic                vPrev;
  logic                vFall, vRise;
  logic [PIXEL_W-1:0]  memDataQ;
  logic [PIXEL_W-1:0]  pixelQ;
  logic                drawDelayed;
  logic [2:0]          syncOut;

  assign vFall    = vPrev & ~vSyncIn;
  assign vRise    = ~vPrev & vSyncIn;
  assign backBank = ~displayBank;

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      memAddr     <= '0;
      memDataQ    <= '0;
      pixelQ      <= '0;
      vPrev       <= 1'b1;
      frameStart  <= 1'b0;
      displayBank <= 1'b0;
    end else begin
      memAddr    <= {displayBank, yCoord, xCoord};
      memDataQ   <= memData;
      pixelQ     <= memDataQ;
      vPrev      <= vSyncIn;
      frameStart <= vRise;
      if (bankToggle) displayBank <= ~displayBank;
    end
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Falls are only acted on in PENDING, so one swap per request per vertical sync.
  always_comb begin
    nextState  = state;
    bankToggle = 1'b0;
    swapAck    = 1'b0;
    case (state)
      IDLE: begin
        if (swapReq) nextState = PENDING;
      end
      PENDING: begin
        if (vFall) begin
          nextState  = ACK;
          bankToggle = 1'b1;
        end
      end
      ACK: begin
        swapAck = 1'b1;
        if (!swapReq) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Syncs idle high, draw idles low.
  sync_delay_line #(
    .WIDTH      (3),
    .DEPTH      (L),
    .RESET_VALUE(3'b110)
  ) u_syncDelay (
    .clk25  (clk25),
    .reset  (reset),
    .dataIn ({hSyncIn, vSyncIn, draw}),
    .dataOut(syncOut)
  );

  assign hSyncOut    = syncOut[2];
  assign vSyncOut    = syncOut[1];
  assign drawDelayed = syncOut[0];

  assign {red, green, blue} = drawDelayed ? pixelQ : '0;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb/tb_vga_pixel_fetch.sv - directed self-checking bench for vga_pixel_fetch
module tb_vga_pixel_fetch;

  logic        clk25;
  logic        reset;
  logic        draw;
  logic [7:0]  xCoord;
  logic [8:0]  yCoord;
  logic        hSyncIn, vSyncIn, swapReq;

  logic [17:0] memAddr1, memAddr2, memAddr4;
  logic [7:0]  memData1, memData2, memData4;
  logic        swapAck1, swapAck2, swapAck4;
  logic        backBank1, backBank2, backBank4;
  logic        frameStart1, frameStart2, frameStart4;
  logic [2:0]  red1, red2, red4, green1, green2, green4;
  logic [1:0]  blue1, blue2, blue4;
  logic        hSyncOut1, hSyncOut2, hSyncOut4, vSyncOut1, vSyncOut2, vSyncOut4;
  logic [7:0]  rgb1, rgb2, rgb4;

  int nChecks = 0;
  int nFails  = 0;

  assign rgb1 = {red1, green1, blue1};
  assign rgb2 = {red2, green2, blue2};
  assign rgb4 = {red4, green4, blue4};

  vga_pixel_fetch #(.MEM_LATENCY(2)) dut (
    .clk25(clk25), .reset(reset), .draw(draw), .xCoord(xCoord), .yCoord(yCoord),
    .hSyncIn(hSyncIn), .vSyncIn(vSyncIn), .memAddr(memAddr2), .memData(memData2),
    .swapReq(swapReq), .swapAck(swapAck2), .backBank(backBank2), .frameStart(frameStart2),
    .red(red2), .green(green2), .blue(blue2), .hSyncOut(hSyncOut2), .vSyncOut(vSyncOut2)
  );

  vga_pixel_fetch #(.MEM_LATENCY(1)) dutLat1 (
    .clk25(clk25), .reset(reset), .draw(draw), .xCoord(xCoord), .yCoord(yCoord),
    .hSyncIn(hSyncIn), .vSyncIn(vSyncIn), .memAddr(memAddr1), .memData(memData1),
    .swapReq(swapReq), .swapAck(swapAck1), .backBank(backBank1), .frameStart(frameStart1),
    .red(red1), .green(green1), .blue(blue1), .hSyncOut(hSyncOut1), .vSyncOut(vSyncOut1)
  );

  vga_pixel_fetch #(.MEM_LATENCY(4)) dutLat4 (
    .clk25(clk25), .reset(reset), .draw(draw), .xCoord(xCoord), .yCoord(yCoord),
    .hSyncIn(hSyncIn), .vSyncIn(vSyncIn), .memAddr(memAddr4), .memData(memData4),
    .swapReq(swapReq), .swapAck(swapAck4), .backBank(backBank4), .frameStart(frameStart4),
    .red(red4), .green(green4), .blue(blue4), .hSyncOut(hSyncOut4), .vSyncOut(vSyncOut4)
  );

  // Frame memory contents: one marked pixel, everything else a fixed pattern.
  function automatic logic [7:0] memFn(input logic [17:0] a);
    return (a == 18'h00705) ? 8'hE3 : (a[7:0] ^ 8'h5A);
  endfunction

  logic [7:0] pipe2;
  logic [7:0] pipe4 [3];

  assign memData1 = memFn(memAddr1);
  assign memData2 = pipe2;
  assign memData4 = pipe4[2];

  always @(posedge clk25) begin
    pipe2    <= memFn(memAddr2);
    pipe4[0] <= memFn(memAddr4);
    pipe4[1] <= pipe4[0];
    pipe4[2] <= pipe4[1];
  end

  initial clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic idleInputs();
    draw = 1'b0; xCoord = 8'd0; yCoord = 9'd0;
    hSyncIn = 1'b1; vSyncIn = 1'b1; swapReq = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    idleInputs();
    repeat (2) @(posedge clk25);
    #1 reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idleInputs();
    draw = 1'b1; xCoord = 8'h33; yCoord = 9'h44; hSyncIn = 1'b0;
    repeat (3) @(posedge clk25);
    #1;
    nChecks++; if (memAddr2 !== 18'h0) begin nFails++; $display("FAIL reset_memAddr: got %h expected %h", memAddr2, 18'h0); end
    nChecks++; if (rgb2 !== 8'h00) begin nFails++; $display("FAIL reset_rgb: got %h expected %h", rgb2, 8'h00); end
    nChecks++; if (swapAck2 !== 1'b0) begin nFails++; $display("FAIL reset_swapAck: got %b expected 0", swapAck2); end
    nChecks++; if (frameStart2 !== 1'b0) begin nFails++; $display("FAIL reset_frameStart: got %b expected 0", frameStart2); end
    nChecks++; if (backBank2 !== 1'b1) begin nFails++; $display("FAIL reset_backBank: got %b expected 1", backBank2); end
    nChecks++; if (hSyncOut2 !== 1'b1) begin nFails++; $display("FAIL reset_hSyncOut: got %b expected 1", hSyncOut2); end
    nChecks++; if (vSyncOut2 !== 1'b1) begin nFails++; $display("FAIL reset_vSyncOut: got %b expected 1", vSyncOut2); end
    idleInputs();
    reset = 1'b0;
    tick();
    vSyncIn = 1'b0;
    tick(); tick();
    nChecks++; if (backBank2 !== 1'b1) begin nFails++; $display("FAIL reset_first_fall_bank: got %b expected 1", backBank2); end
    nChecks++; if (swapAck2 !== 1'b0) begin nFails++; $display("FAIL reset_first_fall_ack: got %b expected 0", swapAck2); end
    vSyncIn = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    logic [7:0] exp1, exp2, exp4;
    doReset();
    repeat (6) tick();
    draw = 1'b1; xCoord = 8'd5; yCoord = 9'd7;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 1) begin
        nChecks++; if (memAddr2 !== 18'h00705) begin nFails++; $display("FAIL latency_memAddr: got %h expected %h", memAddr2, 18'h00705); end
        draw = 1'b0; xCoord = 8'd0; yCoord = 9'd0;
      end
      exp1 = (e == 3) ? 8'hE3 : 8'h00;
      exp2 = (e == 4) ? 8'hE3 : 8'h00;
      exp4 = (e == 6) ? 8'hE3 : 8'h00;
      nChecks++; if (rgb2 !== exp2) begin nFails++; $display("FAIL latency_rgb_lat2 cycle %0d: got %h expected %h", e, rgb2, exp2); end
      nChecks++; if (rgb1 !== exp1) begin nFails++; $display("FAIL latency_rgb_lat1 cycle %0d: got %h expected %h", e, rgb1, exp1); end
      nChecks++; if (rgb4 !== exp4) begin nFails++; $display("FAIL latency_rgb_lat4 cycle %0d: got %h expected %h", e, rgb4, exp4); end
    end
    nChecks++; if ({red2, green2, blue2} !== 8'h00 || red1 !== 3'd0) begin nFails++; $display("FAIL latency_tail: got %h expected 00", rgb2); end
  endtask

  task automatic test_draw_gating();
    logic [7:0] exp2;
    doReset();
    draw = 1'b0; xCoord = 8'hA5; yCoord = 9'd0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      nChecks++; if (rgb2 !== 8'h00) begin nFails++; $display("FAIL gating_blank cycle %0d: got %h expected 00", e, rgb2); end
    end
    draw = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      exp2 = (e >= 4) ? 8'hFF : 8'h00;
      nChecks++; if (rgb2 !== exp2) begin nFails++; $display("FAIL gating_draw cycle %0d: got %h expected %h", e, rgb2, exp2); end
    end
    draw = 1'b0;
  endtask

  task automatic test_hsync_delay();
    int firstLow, lowCount;
    doReset();
    firstLow = -1; lowCount = 0;
    hSyncIn = 1'b0;
    for (int e = 1; e <= 110; e++) begin
      tick();
      if (e == 96) hSyncIn = 1'b1;
      if (hSyncOut2 === 1'b0) begin
        lowCount++;
        if (firstLow < 0) firstLow = e;
      end
    end
    nChecks++; if (firstLow !== 4) begin nFails++; $display("FAIL hsync_shift: got %0d expected 4", firstLow); end
    nChecks++; if (lowCount !== 96) begin nFails++; $display("FAIL hsync_width: got %0d expected 96", lowCount); end
    nChecks++; if (vSyncOut2 !== 1'b1) begin nFails++; $display("FAIL hsync_vsync_idle: got %b expected 1", vSyncOut2); end
  endtask

  task automatic test_frame_start();
    int cnt, firstT;
    doReset();
    for (int f = 0; f < 2; f++) begin
      cnt = 0; firstT = -1;
      vSyncIn = 1'b0;
      for (int e = 1; e <= 3; e++) begin
        tick();
        if (frameStart2 === 1'b1) cnt++;
      end
      vSyncIn = 1'b1;
      for (int e = 1; e <= 6; e++) begin
        tick();
        if (frameStart2 === 1'b1) begin
          cnt++;
          if (firstT < 0) firstT = e;
        end
      end
      nChecks++; if (cnt !== 1) begin nFails++; $display("FAIL frameStart_count frame %0d: got %0d expected 1", f, cnt); end
      nChecks++; if (firstT !== 1) begin nFails++; $display("FAIL frameStart_timing frame %0d: got %0d expected 1", f, firstT); end
    end
  endtask

  task automatic test_swap_mid_frame();
    doReset();
    tick();
    swapReq = 1'b1;
    repeat (5) tick();
    nChecks++; if (backBank2 !== 1'b1) begin nFails++; $display("FAIL swap_wait_bank: got %b expected 1", backBank2); end
    nChecks++; if (swapAck2 !== 1'b0) begin nFails++; $display("FAIL swap_wait_ack: got %b expected 0", swapAck2); end
    vSyncIn = 1'b0;
    tick();
    nChecks++; if (swapAck2 !== 1'b1) begin nFails++; $display("FAIL swap_ack: got %b expected 1", swapAck2); end
    nChecks++; if (backBank2 !== 1'b0) begin nFails++; $display("FAIL swap_backBank: got %b expected 0", backBank2); end
    nChecks++; if (memAddr2[17] !== 1'b0) begin nFails++; $display("FAIL swap_addr_old_bank: got %b expected 0", memAddr2[17]); end
    tick();
    nChecks++; if (memAddr2[17] !== 1'b1) begin nFails++; $display("FAIL swap_addr_new_bank: got %b expected 1", memAddr2[17]); end
    tick();
    vSyncIn = 1'b1;
    repeat (3) tick();
    vSyncIn = 1'b0;
    repeat (2) tick();
    nChecks++; if (backBank2 !== 1'b0) begin nFails++; $display("FAIL swap_single_toggle: got %b expected 0", backBank2); end
    nChecks++; if (swapAck2 !== 1'b1) begin nFails++; $display("FAIL swap_ack_held: got %b expected 1", swapAck2); end
    vSyncIn = 1'b1;
    swapReq = 1'b0;
    tick();
    nChecks++; if (swapAck2 !== 1'b0) begin nFails++; $display("FAIL swap_ack_release: got %b expected 0", swapAck2); end
  endtask

  task automatic test_swap_late_release();
    doReset();
    swapReq = 1'b1;
    tick();
    swapReq = 1'b0;
    tick();
    nChecks++; if (backBank2 !== 1'b1) begin nFails++; $display("FAIL late_release_pending_bank: got %b expected 1", backBank2); end
    vSyncIn = 1'b0;
    tick();
    nChecks++; if (backBank2 !== 1'b0) begin nFails++; $display("FAIL late_release_toggle: got %b expected 0", backBank2); end
    nChecks++; if (swapAck2 !== 1'b1) begin nFails++; $display("FAIL late_release_ack: got %b expected 1", swapAck2); end
    tick();
    nChecks++; if (swapAck2 !== 1'b0) begin nFails++; $display("FAIL late_release_exit: got %b expected 0", swapAck2); end
    vSyncIn = 1'b1;
    tick();
  endtask

  task automatic test_swap_same_cycle();
    doReset();
    repeat (2) tick();
    swapReq = 1'b1;
    vSyncIn = 1'b0;
    tick();
    nChecks++; if (backBank2 !== 1'b1) begin nFails++; $display("FAIL same_cycle_no_toggle: got %b expected 1", backBank2); end
    repeat (3) tick();
    nChecks++; if (swapAck2 !== 1'b0) begin nFails++; $display("FAIL same_cycle_no_ack: got %b expected 0", swapAck2); end
    vSyncIn = 1'b1;
    repeat (4) tick();
    vSyncIn = 1'b0;
    tick();
    nChecks++; if (backBank2 !== 1'b0) begin nFails++; $display("FAIL same_cycle_next_toggle: got %b expected 0", backBank2); end
    nChecks++; if (swapAck2 !== 1'b1) begin nFails++; $display("FAIL same_cycle_next_ack: got %b expected 1", swapAck2); end
    swapReq = 1'b0;
    vSyncIn = 1'b1;
    tick();
  endtask

  task automatic test_reset_pending();
    doReset();
    swapReq = 1'b1;
    tick();
    vSyncIn = 1'b0;
    tick();
    vSyncIn = 1'b1;
    swapReq = 1'b0;
    repeat (2) tick();
    nChecks++; if (backBank2 !== 1'b0) begin nFails++; $display("FAIL reset_pending_setup: got %b expected 0", backBank2); end
    swapReq = 1'b1;
    tick();
    #5 reset = 1'b1;
    #1;
    nChecks++; if (swapAck2 !== 1'b0) begin nFails++; $display("FAIL reset_pending_ack: got %b expected 0", swapAck2); end
    nChecks++; if (backBank2 !== 1'b1) begin nFails++; $display("FAIL reset_pending_bank: got %b expected 1", backBank2); end
    swapReq = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    vSyncIn = 1'b0;
    repeat (2) tick();
    nChecks++; if (backBank2 !== 1'b1) begin nFails++; $display("FAIL reset_pending_no_swap: got %b expected 1", backBank2); end
    nChecks++; if (swapAck2 !== 1'b0) begin nFails++; $display("FAIL reset_pending_no_ack: got %b expected 0", swapAck2); end
    vSyncIn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_draw_gating();
    test_hsync_delay();
    test_frame_start();
    test_swap_mid_frame();
    test_swap_late_release();
    test_swap_same_cycle();
    test_reset_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fetch.md
VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 2, frame-memory read latency in clk25 cycles, legal range 1..4.
REQ-002 SHALL have ports: clk25 input 1 pixel clock; reset input 1 asynchronous, active-high.
REQ-003 draw input 1: pixel position is inside the active 256x320 region.
REQ-004 xCoord input 8: pixel column, 0..255.
REQ-005 yCoord input 9: pixel row, 0..319.
REQ-006 hSyncIn input 1 and vSyncIn input 1: raw syncs from the timing generator.
REQ-007 memAddr output 18: frame-memory read address {bank, yCoord, xCoord}.
REQ-008 memData input 8: memory read data, 3-3-2 RGB.
REQ-009 swapReq input 1 and swapAck output 1: four-phase buffer-swap handshake.
REQ-010 backBank output 1: bank that upstream logic may write, always equal to ~displayBank.
REQ-011 frameStart output 1: one-cycle pulse marking frame start.
REQ-012 red output 3, green output 3, blue output 2, hSyncOut output 1, vSyncOut output 1.

Function
REQ-013 SHALL register memAddr = {displayBank, yCoord, xCoord} on every clk25 edge, with no gating by draw.
REQ-014 SHALL sample memData exactly MEM_LATENCY cycles after the corresponding memAddr update, then register it to the RGB outputs.
REQ-015 SHALL make total latency L = MEM_LATENCY+2 cycles from an input (x, y, draw) to the matching RGB output.
REQ-016 SHALL delay hSyncIn, vSyncIn and draw by exactly L cycles through shift registers, so syncs stay aligned with RGB.
REQ-017 SHALL drive RGB = 0 when the L-delayed draw is 0, regardless of memData.
REQ-018 SHALL detect vSyncIn edges using one registered copy of vSyncIn (vPrev).
REQ-019 Fall = vPrev & ~vSyncIn; rise = ~vPrev & vSyncIn.
REQ-020 SHALL pulse frameStart high for exactly one cycle, the cycle after a vSyncIn rise is detected.
REQ-021 Swap FSM states SHALL be IDLE, PENDING and ACK.
REQ-022 IDLE -> PENDING when swapReq = 1.
REQ-023 PENDING -> ACK on a vSyncIn fall; on that same edge displayBank SHALL toggle.
REQ-024 ACK SHALL hold swapAck = 1; ACK -> IDLE when swapReq = 0.
REQ-025 swapAck SHALL be 0 in IDLE and PENDING.
REQ-026 If swapReq rises in the same cycle as a vSyncIn fall while in IDLE, the FSM SHALL enter PENDING and swap at the next fall, not the current one.
REQ-027 Deassertion of swapReq in PENDING SHALL NOT cancel the swap; the swap still completes, then ACK exits immediately once swapReq = 0.
REQ-028 SHALL allow at most one bank toggle per vertical sync.
REQ-029 memAddr SHALL use the new bank starting the cycle after the toggle; the toggle falls in vertical blank, so no visible pixel mixes banks.
REQ-030 SHALL NOT detect any vSyncIn fall while FSM is in IDLE or ACK.

Reset
REQ-031 On reset SHALL clear red, green, blue, memAddr, swapAck, frameStart, displayBank (0), vPrev (1) and all delay stages; SHALL set FSM to IDLE.
REQ-032 Delayed hSyncOut and vSyncOut stages SHALL reset to 1, so outputs are idle-high.
REQ-033 backBank SHALL be 1 after reset.
REQ-034 Reset asserted mid-frame or mid-handshake SHALL abort any pending swap.
REQ-035 After reset release, the first fall SHALL produce no swap unless swapReq was seen after reset release.

Structure
REQ-036 A shared package SHALL hold: the swap-state encoding (IDLE=0, PENDING=1, ACK=2), the 18-bit address width, and the 3-3-2 colour field widths.
REQ-037 One sub-module, sync_delay_line (parameterised width and depth, reset value 1), SHALL implement the hSync/vSync/draw shift registers.

Verification
REQ-038 Reset, then draw=1, x=5, y=7, bank 0 -> memAddr = 18'h00705 one cycle later; with memData = 8'hE3 returned after MEM_LATENCY=2, red=7, green=0, blue=3 appear 4 cycles after input.
REQ-039 draw=0 with memData = 8'hFF -> RGB = 0; hSyncIn pulse low for 96 cycles -> hSyncOut low for 96 cycles, shifted by exactly L.
REQ-040 swapReq=1 mid-frame -> no toggle until vSyncIn falls; then displayBank=1, memAddr[17]=1, swapAck=1; swapReq=0 -> swapAck=0 next cycle.
REQ-041 swapReq rising in the same cycle as a vSyncIn fall -> swap occurs one frame later (next fall).
REQ-042 Reset asserted while in PENDING -> swapAck=0, displayBank=0, backBank=1; the next fall produces no toggle.
REQ-043 Two consecutive vSyncIn rises -> exactly one frameStart pulse each; MEM_LATENCY=1 and 4 builds -> RGB latency 3 and 6 respectively.
